// File: rtl/cpu_bus_responder.sv
// CPU bus responder: 2 KB RAM, PPU register window, PRG ROM window and open-bus read data.
// Define OAM_DMA_EN to build the $4014 OAM DMA engine; without it $4014 is unmapped.
module cpu_bus_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [7:0]  bus_rdata,
    output logic [2:0]  ppu_reg,
    output logic [7:0]  ppu_wdata,
    output logic        ppu_we,
    output logic        ppu_re,
    input  logic [7:0]  ppu_rdata,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_rdata,
    output logic        cpu_halt
);

    localparam int unsigned RAM_AW    = 11;
    localparam int unsigned RAM_DEPTH = 2048;
    localparam int unsigned DW        = 8;

    logic [DW-1:0]     r_ram [RAM_DEPTH];
    logic [DW-1:0]     r_rdata;
    logic              w_sel_ram;
    logic              w_sel_ppu;
    logic              w_sel_prg;
    logic              w_bus_ok;
    logic              w_dma_active;
    logic              w_dma_we;
    logic [DW-1:0]     w_dma_wdata;
    logic [RAM_AW-1:0] w_ram_raddr;
    logic [DW-1:0]     w_ram_rd;

    assign w_sel_ram = (bus_addr[15:13] == 3'b000);
    assign w_sel_ppu = (bus_addr[15:13] == 3'b001);
    assign w_sel_prg = bus_addr[15];
    assign w_bus_ok  = ~w_dma_active;
    assign prg_addr  = bus_addr[14:0];
    assign bus_rdata = r_rdata;
    assign w_ram_rd  = r_ram[w_ram_raddr];

`ifdef OAM_DMA_EN
    typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_READ, ST_WRITE} dma_state_e;

    dma_state_e    r_state;
    dma_state_e    w_state_nxt;
    logic [DW-1:0] r_page;
    logic [DW-1:0] r_idx;
    logic [DW-1:0] r_byte;
    logic          w_trigger;

    assign w_trigger    = w_bus_ok && bus_we && (bus_addr == 16'h4014);
    assign w_dma_active = (r_state != ST_IDLE);
    assign w_dma_wdata  = r_byte;
    assign cpu_halt     = w_dma_active;
    // DMA owns the single RAM read port while the CPU is halted
    assign w_ram_raddr  = w_dma_active ? {r_page[2:0], r_idx} : bus_addr[10:0];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dma_we    = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_trigger) w_state_nxt = ST_ALIGN;
            ST_ALIGN: w_state_nxt = ST_READ;
            ST_READ:  w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                w_dma_we    = 1'b1;
                w_state_nxt = (r_idx == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Pages at or above $20 are outside internal RAM and transfer zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            r_page <= '0;
            r_idx  <= '0;
            r_byte <= '0;
        end else begin
            if (w_trigger)          r_page <= bus_wdata;
            if (r_state == ST_READ) r_byte <= (r_page < 8'h20) ? w_ram_rd : 8'h00;
            if (r_state == ST_WRITE) r_idx <= r_idx + 8'd1;
        end
    end
`else
    assign w_dma_active = 1'b0;
    assign w_dma_we     = 1'b0;
    assign w_dma_wdata  = 8'h00;
    assign cpu_halt     = 1'b0;
    assign w_ram_raddr  = bus_addr[10:0];
`endif

    // RAM has no reset; contents survive rst
    always_ff @(posedge clk) begin
        if (w_bus_ok && bus_we && w_sel_ram) r_ram[bus_addr[RAM_AW-1:0]] <= bus_wdata;
    end

    // Unmapped reads, writes and halted cycles leave the open-bus value in place
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_bus_ok && !bus_we) begin
            if (w_sel_ram)      r_rdata <= w_ram_rd;
            else if (w_sel_ppu) r_rdata <= ppu_rdata;
            else if (w_sel_prg) r_rdata <= prg_rdata;
        end
    end

    always_comb begin
        ppu_reg   = bus_addr[2:0];
        ppu_wdata = bus_wdata;
        ppu_we    = 1'b0;
        ppu_re    = 1'b0;
        if (w_dma_we) begin
            ppu_reg   = 3'd4;
            ppu_wdata = w_dma_wdata;
            ppu_we    = 1'b1;
        end else if (w_bus_ok && w_sel_ppu) begin
            ppu_we = bus_we;
            ppu_re = bus_re & ~bus_we;
        end
    end

endmodule
